lane_game_core: RTL and testbench
=================================

LANE_GAME_CORE -- requirements
Module: lane_game_core

Interface
REQ-001 SHALL have parameter COLS, default 8: columns per lane; frog column one-hot width.
REQ-002 SHALL have parameter ROWS, default 8: lane count; row 0 = goal, row ROWS-1 = start.
REQ-003 SHALL have parameter TICK_DIV, default 3125000: clk cycles per game tick.
REQ-004 SHALL have parameter LANE_INIT, default all zeros, width ROWS*COLS: reset bitmap; lane r = bits [r*COLS +: COLS].
REQ-005 SHALL have parameter LANE_DIR, default all zeros, width ROWS: bit r = 1 rotates lane r toward MSB; 0 rotates toward LSB.
REQ-006 SHALL have parameter LANE_RATE, default all zeros, width ROWS*4: lane r rotates once per (LANE_RATE[r*4 +: 4] + 1) ticks.
REQ-007 SHALL have parameter LIVES, default 3, range 1..7: lives at reset and restart.
REQ-008 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-009 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-010 SHALL have ports up_n, down_n, left_n, right_n, input, 1 each: active-low buttons, asynchronous to clk.
REQ-011 SHALL have port start, input, 1: active-high restart request, honoured only in OVER.
REQ-012 SHALL have port lanes, output, ROWS*COLS: current lane bitmaps, same packing as LANE_INIT.
REQ-013 SHALL have port frog_row, output, $clog2(ROWS): frog row.
REQ-014 SHALL have port frog_col, output, COLS: frog column, one-hot.
REQ-015 SHALL have port state, output, 2: 0 PLAY, 1 HIT, 2 WIN, 3 OVER.
REQ-016 SHALL have ports lives, output, 3, and score, output, 8.
REQ-017 SHALL have port tick, output, 1: one-cycle pulse per game tick.

Function
REQ-018 SHALL run tick counter 0..TICK_DIV-1 in every state and pulse tick in the cycle count == TICK_DIV-1.
REQ-019 SHALL keep per-lane rate counter; on tick, lane at rate limit rotates by one column per LANE_DIR, counter clears; else counter increments.
REQ-020 SHALL freeze lane rotation in OVER only.
REQ-021 SHALL force rows 0 and ROWS-1 to zero on lanes output and treat them as always safe.
REQ-022 SHALL pass each button through a 2-flop synchronizer plus edge register; one move per falling edge; held button gives no repeat.
REQ-023 SHALL update frog on the 3rd clk edge after a synchronized input falls: 2 sync edges, 1 edge-detect/update edge.
REQ-024 SHALL accept moves only in PLAY; edges in other states are discarded, not queued.
REQ-025 SHALL resolve simultaneous edges in one cycle by priority up > down > left > right, one move only; others discarded.
REQ-026 SHALL decrement frog_row on up, increment on down; down at ROWS-1 is ignored.
REQ-027 SHALL shift frog_col toward LSB on right and toward MSB on left; right at bit 0 and left at bit COLS-1 are ignored; no wrap.
REQ-028 SHALL detect collision in PLAY when frog_row is a hazard row and (lane[frog_row] & frog_col) != 0, using registered values, and enter HIT on the next edge.
REQ-029 SHALL, when a move and a lane rotation occur in the same cycle, check collision on the post-update values in the following cycle.
REQ-030 SHALL enter WIN on the edge after frog_row becomes 0, with score incremented at that edge, saturating at 255.
REQ-031 SHALL, in HIT, wait for the next tick, then decrement lives and return frog to start; go to OVER if lives was 1, else go to PLAY.
REQ-032 SHALL, in WIN, wait for the next tick, then return frog to start and go to PLAY; lives unchanged.
REQ-033 SHALL define frog start as row ROWS-1, frog_col = 1 << (COLS/2).
REQ-034 SHALL, in OVER with start = 1, restore reset values of lanes, frog, lives and score, and enter PLAY on the next edge.

Reset
REQ-035 SHALL on reset low immediately set lanes = LANE_INIT (rows 0 and ROWS-1 masked), frog at start, state PLAY, lives = LIVES, score 0, tick 0, and clear all counters and synchronizers to released (1).
REQ-036 SHALL on reset asserted mid-HIT or mid-WIN abandon the pending transition and not change lives or score.

Verification (COLS=8, ROWS=8, TICK_DIV=4, LANE_RATE=0, LIVES=3)
REQ-037 SHALL check: release reset -> tick high at cycles 3, 7, 11; LANE_DIR[2]=1 with lane2 = 0x11 -> lane2 = 0x22 after first tick.
REQ-038 SHALL check: up_n held low 20 cycles -> frog_row 7->6 exactly once, 3 edges after fall; right_n pressed at frog_col = 0x01 -> unchanged.
REQ-039 SHALL check: up_n and left_n fall in the same cycle -> only row decrements; frog_col stays 0x10.
REQ-040 SHALL check: frog at row 6 with lane6 = 0x10 -> HIT next cycle; lives 3->2 and frog at row 7, col 0x10 after next tick.
REQ-041 SHALL check: 3 hits -> OVER, lanes frozen; start = 1 -> PLAY with lives 3, score 0, lanes = LANE_INIT.
REQ-042 SHALL check: 7 ups on clear lanes -> WIN, score 1, frog back at start after next tick; reset during WIN -> score 0, state PLAY.

Source files
------------

// File: rtl/lane_game_core.sv
// rtl/lane_game_core.sv - lane-crossing game core: scrolling lanes, frog movement, hit/win/over flow
module lane_game_core #(
   parameter int                     COLS      = 8,
   parameter int                     ROWS      = 8,
   parameter int                     TICK_DIV  = 3125000,
   parameter logic [ROWS*COLS-1:0]   LANE_INIT = '0,
   parameter logic [ROWS-1:0]        LANE_DIR  = '0,
   parameter logic [ROWS*4-1:0]      LANE_RATE = '0,
   parameter int                     LIVES     = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      up_n,
   input  logic                      down_n,
   input  logic                      left_n,
   input  logic                      right_n,
   input  logic                      start,
   output logic [ROWS*COLS-1:0]      lanes,
   output logic [$clog2(ROWS)-1:0]   frog_row,
   output logic [COLS-1:0]           frog_col,
   output logic [1:0]                state,
   output logic [2:0]                lives,
   output logic [7:0]                score,
   output logic                      tick
);

   localparam int RW = $clog2(ROWS);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [RW-1:0]        START_ROW  = RW'(ROWS - 1);
   localparam logic [COLS-1:0]      START_COL  = {{(COLS-1){1'b0}}, 1'b1} << (COLS / 2);
   localparam logic [2:0]           LIVES_INIT = 3'(LIVES);
   // Goal and start rows never carry hazards.
   localparam logic [ROWS*COLS-1:0] ROW_MASK   = {{COLS{1'b0}}, {((ROWS-2)*COLS){1'b1}}, {COLS{1'b0}}};

   typedef enum logic [1:0] {
      S_PLAY = 2'd0,
      S_HIT  = 2'd1,
      S_WIN  = 2'd2,
      S_OVER = 2'd3
   } state_t;

   state_t                r_state;
   logic [TW-1:0]         r_tick_cnt;
   logic [ROWS*COLS-1:0]  r_lanes;
   logic [ROWS*4-1:0]     r_rate_cnt;
   logic [3:0]            r_sync1;
   logic [3:0]            r_sync2;
   logic [3:0]            r_prev;
   logic [RW-1:0]         r_row;
   logic [COLS-1:0]       r_col;
   logic [2:0]            r_lives;
   logic [7:0]            r_score;

   logic                  w_tick;
   logic [ROWS*COLS-1:0]  w_lanes_rot;
   logic [ROWS-1:0]       w_rate_hit;
   logic [3:0]            w_btn_n;
   logic [3:0]            w_fall;
   logic [COLS-1:0]       w_row_lane;
   logic                  w_hazard;
   logic                  w_hit;

   assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

   // Free-running game tick divider, active in every state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + TW'(1);
      end
   end

   for (genvar g = 0; g < ROWS; g++) begin : g_lane
      logic [COLS-1:0] w_cur;
      assign w_cur = r_lanes[g*COLS +: COLS];
      assign w_lanes_rot[g*COLS +: COLS] = LANE_DIR[g] ? {w_cur[COLS-2:0], w_cur[COLS-1]}
                                                       : {w_cur[0], w_cur[COLS-1:1]};
      assign w_rate_hit[g] = (r_rate_cnt[g*4 +: 4] == LANE_RATE[g*4 +: 4]);
   end

   // Lane scrolling: each lane rotates once its rate counter reaches its limit; frozen in OVER.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lanes    <= LANE_INIT;
         r_rate_cnt <= '0;
      end else if (r_state == S_OVER) begin
         if (start) begin
            r_lanes    <= LANE_INIT;
            r_rate_cnt <= '0;
         end
      end else if (w_tick) begin
         for (int r = 0; r < ROWS; r++) begin
            if (w_rate_hit[r]) begin
               r_rate_cnt[r*4 +: 4]    <= 4'd0;
               r_lanes[r*COLS +: COLS] <= w_lanes_rot[r*COLS +: COLS];
            end else begin
               r_rate_cnt[r*4 +: 4]    <= r_rate_cnt[r*4 +: 4] + 4'd1;
            end
         end
      end
   end

   assign w_btn_n = {up_n, down_n, left_n, right_n};
   assign w_fall  = r_prev & ~r_sync2;

   // Two-flop synchronizer plus edge register for the buttons; released level is 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
         r_prev  <= 4'hF;
      end else begin
         r_sync1 <= w_btn_n;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Select the lane under the frog's current row.
   always_comb begin
      w_row_lane = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (r_row == RW'(r)) begin
            w_row_lane = r_lanes[r*COLS +: COLS];
         end
      end
   end

   assign w_hazard = (r_row != '0) && (r_row != START_ROW);
   assign w_hit    = w_hazard && ((w_row_lane & r_col) != '0);

   // Game FSM: frog movement, collision, win, lives and score.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_PLAY;
         r_row   <= START_ROW;
         r_col   <= START_COL;
         r_lives <= LIVES_INIT;
         r_score <= 8'd0;
      end else begin
         case (r_state)
            S_PLAY: begin
               if (w_hit) begin
                  r_state <= S_HIT;
               end else if (r_row == '0) begin
                  r_state <= S_WIN;
                  if (r_score != 8'hFF) begin
                     r_score <= r_score + 8'd1;
                  end
               end else if (w_fall[3]) begin
                  r_row <= r_row - RW'(1);
               end else if (w_fall[2]) begin
                  if (r_row != START_ROW) begin
                     r_row <= r_row + RW'(1);
                  end
               end else if (w_fall[1]) begin
                  if (!r_col[COLS-1]) begin
                     r_col <= r_col << 1;
                  end
               end else if (w_fall[0]) begin
                  if (!r_col[0]) begin
                     r_col <= r_col >> 1;
                  end
               end
            end
            S_HIT: begin
               if (w_tick) begin
                  r_lives <= r_lives - 3'd1;
                  r_row   <= START_ROW;
                  r_col   <= START_COL;
                  r_state <= (r_lives == 3'd1) ? S_OVER : S_PLAY;
               end
            end
            S_WIN: begin
               if (w_tick) begin
                  r_row   <= START_ROW;
                  r_col   <= START_COL;
                  r_state <= S_PLAY;
               end
            end
            default: begin
               if (start) begin
                  r_row   <= START_ROW;
                  r_col   <= START_COL;
                  r_lives <= LIVES_INIT;
                  r_score <= 8'd0;
                  r_state <= S_PLAY;
               end
            end
         endcase
      end
   end

   assign lanes    = r_lanes & ROW_MASK;
   assign frog_row = r_row;
   assign frog_col = r_col;
   assign state    = r_state;
   assign lives    = r_lives;
   assign score    = r_score;
   assign tick     = w_tick;

endmodule

// File: tb/tb_lane_game_core.sv
// tb/tb_lane_game_core.sv - self-checking bench for lane_game_core
module tb_lane_game_core;

   localparam int          COLS     = 8;
   localparam int          ROWS     = 8;
   localparam int          TICK_DIV = 4;
   localparam int          LIVES    = 3;
   // Row 6 is solid, row 2 scrolls toward MSB, row 3 toward LSB, row 4 toward MSB every 2nd tick.
   localparam logic [63:0] INIT        = 64'hFFFF_0001_0111_00FF;
   localparam logic [63:0] INIT_MASKED = 64'h00FF_0001_0111_0000;
   localparam logic [7:0]  DIR         = 8'h14;
   localparam logic [31:0] RATE        = 32'h0001_0000;

   localparam logic [1:0]  ST_PLAY = 2'd0;
   localparam logic [1:0]  ST_HIT  = 2'd1;
   localparam logic [1:0]  ST_WIN  = 2'd2;
   localparam logic [1:0]  ST_OVER = 2'd3;

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic        up_n    = 1'b1;
   logic        down_n  = 1'b1;
   logic        left_n  = 1'b1;
   logic        right_n = 1'b1;
   logic        start   = 1'b0;

   logic [63:0] d_lanes, c_lanes;
   logic [2:0]  d_row, c_row;
   logic [7:0]  d_col, c_col;
   logic [1:0]  d_state, c_state;
   logic [2:0]  d_lives, c_lives;
   logic [7:0]  d_score, c_score;
   logic        d_tick, c_tick;

   int checks = 0;
   int errors = 0;
   int ecount;

   typedef struct {
      logic [3:0] btn;
      logic [2:0] row;
      logic [7:0] col;
   } vec_t;

   vec_t tbl [16];

   lane_game_core #(
      .COLS(COLS), .ROWS(ROWS), .TICK_DIV(TICK_DIV),
      .LANE_INIT(INIT), .LANE_DIR(DIR), .LANE_RATE(RATE), .LIVES(LIVES)
   ) u_dut (
      .clk(clk), .reset(reset),
      .up_n(up_n), .down_n(down_n), .left_n(left_n), .right_n(right_n),
      .start(start),
      .lanes(d_lanes), .frog_row(d_row), .frog_col(d_col), .state(d_state),
      .lives(d_lives), .score(d_score), .tick(d_tick)
   );

   lane_game_core #(
      .COLS(COLS), .ROWS(ROWS), .TICK_DIV(TICK_DIV),
      .LANE_INIT(64'h0), .LANE_DIR(8'h00), .LANE_RATE(32'h0), .LIVES(LIVES)
   ) u_clr (
      .clk(clk), .reset(reset),
      .up_n(up_n), .down_n(down_n), .left_n(left_n), .right_n(right_n),
      .start(start),
      .lanes(c_lanes), .frog_row(c_row), .frog_col(c_col), .state(c_state),
      .lives(c_lives), .score(c_score), .tick(c_tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset) begin
      if (!reset) ecount <= 0;
      else        ecount <= ecount + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // mask bits: [3]=up [2]=down [1]=left [0]=right, 1 = pressed
   task automatic drive(input logic [3:0] m);
      {up_n, down_n, left_n, right_n} = ~m;
   endtask

   task automatic wait_leave(input bit use_clr, input logic [1:0] from_st, input string nm);
      int n;
      n = 0;
      while (((use_clr ? c_state : d_state) == from_st) && n < 10) begin
         step(1);
         n++;
      end
      chk({nm, "_timeout"}, 64'(n < 10), 64'(1));
   endtask

   function automatic logic [63:0] model_lanes(input int k);
      logic [7:0] r2, r3, r4;
      r2 = 8'h11;
      r3 = 8'h01;
      r4 = 8'h01;
      for (int i = 0; i < k; i++) begin
         r2 = {r2[6:0], r2[7]};
         r3 = {r3[0], r3[7:1]};
         if (i % 2 == 1) r4 = {r4[6:0], r4[7]};
      end
      return {8'h00, 8'hFF, 8'h00, r4, r3, r2, 8'h00, 8'h00};
   endfunction

   initial begin
      int held;
      int kf;

      tbl[0]  = '{4'b0001, 3'd7, 8'h08};
      tbl[1]  = '{4'b0001, 3'd7, 8'h04};
      tbl[2]  = '{4'b0001, 3'd7, 8'h02};
      tbl[3]  = '{4'b0001, 3'd7, 8'h01};
      tbl[4]  = '{4'b0001, 3'd7, 8'h01};
      tbl[5]  = '{4'b0100, 3'd7, 8'h01};
      tbl[6]  = '{4'b0011, 3'd7, 8'h02};
      tbl[7]  = '{4'b0110, 3'd7, 8'h02};
      tbl[8]  = '{4'b0010, 3'd7, 8'h04};
      tbl[9]  = '{4'b0010, 3'd7, 8'h08};
      tbl[10] = '{4'b0010, 3'd7, 8'h10};
      tbl[11] = '{4'b0010, 3'd7, 8'h20};
      tbl[12] = '{4'b0010, 3'd7, 8'h40};
      tbl[13] = '{4'b0010, 3'd7, 8'h80};
      tbl[14] = '{4'b0010, 3'd7, 8'h80};
      tbl[15] = '{4'b0001, 3'd7, 8'h40};

      // reset values
      step(2);
      chk("rst_lanes", d_lanes, INIT_MASKED);
      chk("rst_row",   64'(d_row),   64'(7));
      chk("rst_col",   64'(d_col),   64'(8'h10));
      chk("rst_state", 64'(d_state), 64'(ST_PLAY));
      chk("rst_lives", 64'(d_lives), 64'(3));
      chk("rst_score", 64'(d_score), 64'(0));
      chk("rst_tick",  64'(d_tick),  64'(0));

      // tick cadence and lane scrolling
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 12; c++) begin
         chk($sformatf("tick_c%0d", c), 64'(d_tick), 64'(c % 4 == 3));
         chk($sformatf("lanes_c%0d", c), d_lanes, model_lanes(ecount / 4));
         @(negedge clk);
      end
      @(posedge clk);
      #1;

      // held up: one move three edges after the fall, then hit on solid row 6
      held = 0;
      drive(4'b1000);
      step(2); held += 2;
      chk("up_lat2_row", 64'(d_row), 64'(7));
      step(1); held += 1;
      chk("up_lat3_row", 64'(d_row), 64'(6));
      chk("up_lat3_col", 64'(d_col), 64'(8'h10));
      step(1); held += 1;
      chk("hit1_state", 64'(d_state), 64'(ST_HIT));
      wait_leave(1'b0, ST_HIT, "hit1");
      chk("hit1_ret_state", 64'(d_state), 64'(ST_PLAY));
      chk("hit1_lives", 64'(d_lives), 64'(2));
      chk("hit1_row",   64'(d_row),   64'(7));
      chk("hit1_col",   64'(d_col),   64'(8'h10));
      while (held < 20) begin
         step(1);
         held++;
      end
      chk("held_no_repeat_row", 64'(d_row), 64'(7));
      drive(4'b0000);
      step(4);

      // up and left in the same cycle: only the row moves
      drive(4'b1010);
      step(3);
      chk("upleft_row", 64'(d_row), 64'(6));
      chk("upleft_col", 64'(d_col), 64'(8'h10));
      step(1);
      drive(4'b0000);
      chk("hit2_state", 64'(d_state), 64'(ST_HIT));
      wait_leave(1'b0, ST_HIT, "hit2");
      chk("hit2_lives", 64'(d_lives), 64'(1));
      chk("hit2_row",   64'(d_row),   64'(7));
      step(3);

      // table of moves along the safe start row
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].btn);
         step(3);
         drive(4'b0000);
         step(3);
         chk($sformatf("vec%0d_row", i), 64'(d_row), 64'(tbl[i].row));
         chk($sformatf("vec%0d_col", i), 64'(d_col), 64'(tbl[i].col));
         chk($sformatf("vec%0d_state", i), 64'(d_state), 64'(ST_PLAY));
      end

      // third hit ends the game
      drive(4'b1000);
      step(4);
      drive(4'b0000);
      chk("hit3_state", 64'(d_state), 64'(ST_HIT));
      wait_leave(1'b0, ST_HIT, "hit3");
      chk("over_state", 64'(d_state), 64'(ST_OVER));
      chk("over_lives", 64'(d_lives), 64'(0));
      kf = ecount / 4;
      chk("over_lanes0", d_lanes, model_lanes(kf));
      drive(4'b0001);
      step(3);
      drive(4'b0000);
      step(7);
      chk("over_frozen", d_lanes, model_lanes(kf));
      chk("over_move_col", 64'(d_col), 64'(8'h10));
      chk("over_move_row", 64'(d_row), 64'(7));

      // restart from OVER
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("restart_state", 64'(d_state), 64'(ST_PLAY));
      chk("restart_lives", 64'(d_lives), 64'(3));
      chk("restart_score", 64'(d_score), 64'(0));
      chk("restart_lanes", d_lanes, INIT_MASKED);
      chk("restart_row",   64'(d_row),   64'(7));

      // win on clear lanes
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      step(1);
      drive(4'b1000); step(3); drive(4'b0000); step(3);
      chk("clr_up_row", 64'(c_row), 64'(6));
      drive(4'b0100); step(3); drive(4'b0000); step(3);
      chk("clr_down_row", 64'(c_row), 64'(7));
      for (int i = 0; i < 7; i++) begin
         drive(4'b1000); step(3); drive(4'b0000);
         if (i < 6) step(3);
      end
      chk("win1_row0", 64'(c_row), 64'(0));
      step(1);
      chk("win1_state", 64'(c_state), 64'(ST_WIN));
      chk("win1_score", 64'(c_score), 64'(1));
      wait_leave(1'b1, ST_WIN, "win1");
      chk("win1_ret_state", 64'(c_state), 64'(ST_PLAY));
      chk("win1_ret_row",   64'(c_row),   64'(7));
      chk("win1_ret_col",   64'(c_col),   64'(8'h10));
      chk("win1_ret_lives", 64'(c_lives), 64'(3));
      chk("win1_ret_score", 64'(c_score), 64'(1));
      step(3);
      for (int i = 0; i < 7; i++) begin
         drive(4'b1000); step(3); drive(4'b0000);
         if (i < 6) step(3);
      end
      step(1);
      chk("win2_state", 64'(c_state), 64'(ST_WIN));
      chk("win2_score", 64'(c_score), 64'(2));
      reset = 1'b0;
      #1;
      chk("winrst_score", 64'(c_score), 64'(0));
      chk("winrst_state", 64'(c_state), 64'(ST_PLAY));
      chk("winrst_row",   64'(c_row),   64'(7));
      chk("winrst_lives", 64'(c_lives), 64'(3));
      reset = 1'b1;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
